// File: rtl/riscv_pkg.sv
// Shared constants for the 5-stage core fetch path.
// Instruction width, NOP encoding and sequential PC step.
package riscv_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR =
    32'h0000_0013;

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Fetch/decode boundary bundle for fetch_stall_ctrl.
// FETCH_STALL_COUNT_EN adds the stall_cycles counter output.
interface fetch_stall_ctrl_if #(
  parameter int XLEN = 64
);
  import riscv_pkg::*;

  logic               stall;
  logic               branch_taken;
  logic [XLEN-1:0]    branch_target;
  logic [INSTR_W-1:0] imem_instr;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               ifid_valid;
  logic               idex_bubble;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0]        stall_cycles;
`endif

`ifdef FETCH_STALL_COUNT_EN
  modport master (
    input  stall, branch_taken,
    input  branch_target, imem_instr,
    output pc, ifid_pc, ifid_instr,
    output ifid_valid, idex_bubble,
    output stall_cycles
  );

  modport slave (
    output stall, branch_taken,
    output branch_target, imem_instr,
    input  pc, ifid_pc, ifid_instr,
    input  ifid_valid, idex_bubble,
    input  stall_cycles
  );
`else
  modport master (
    input  stall, branch_taken,
    input  branch_target, imem_instr,
    output pc, ifid_pc, ifid_instr,
    output ifid_valid, idex_bubble
  );

  modport slave (
    output stall, branch_taken,
    output branch_target, imem_instr,
    input  pc, ifid_pc, ifid_instr,
    input  ifid_valid, idex_bubble
  );
`endif

endinterface

// File: rtl/fetch_stall_ctrl_pc_reg.sv
// Program counter register: reset, redirect, hold or +4.
// Redirect targets are word-aligned by masking the low two bits.
module pc_reg
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            hold,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK =
    ~XLEN'(3);
  localparam logic [XLEN-1:0] STEP =
    XLEN'(PC_STEP);

  logic [XLEN-1:0] tgt_aligned;
  logic [XLEN-1:0] pc_seq;

  // Aligned redirect target and sequential successor.
  always_comb begin
    tgt_aligned = next_pc & ALIGN_MASK;
    pc_seq      = pc + STEP;
  end

  // PC update with reset > load > hold > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= tgt_aligned;
    end else if (!hold) begin
      pc <= pc_seq;
    end
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side stall/redirect control: PC, IF/ID, bubble select.
// FETCH_STALL_COUNT_EN enables the saturating stall counter.
module fetch_stall_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stall_ctrl_if.master bus
);

  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    ifid_pc_q;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic               ifid_valid_q;
  logic               redirect;
  logic               hold;

  // Branch beats stall; bubble covers both.
  always_comb begin
    redirect = bus.branch_taken;
    hold     = bus.stall & ~bus.branch_taken;
  end

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load_en (redirect),
    .hold    (bus.stall),
    .next_pc (bus.branch_target),
    .pc      (pc_q)
  );

  // IF/ID register: flush on redirect, hold on stall.
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (!hold) begin
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= bus.imem_instr;
      ifid_valid_q <= 1'b1;
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of genuinely stalled edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (hold && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt_q;
`endif

  assign bus.pc          = pc_q;
  assign bus.ifid_pc     = ifid_pc_q;
  assign bus.ifid_instr  = ifid_instr_q;
  assign bus.ifid_valid  = ifid_valid_q;
  assign bus.idex_bubble = bus.stall
                         | bus.branch_taken;

endmodule
